fp_multiplier_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 binary floating-point multiplier with valid/ready handshakes, round-to-nearest-even, full special-value handling and exception flags. It succeeds the single-cycle fp32 combinational multiplier. It covers fp16, bf16 and fp32 through the exponent/mantissa width parameters. It sits between the operand issue logic and the result writeback FIFO, and accepts one operation per cycle under backpressure.

---
 rtl/fp_arith_pkg.sv | 34 +++
 rtl/multiplier_nbit.sv | 23 ++
 rtl/fp_multiplier_pipe.sv | 198 +++++++++++++++++++
 tb/tb_fp_multiplier_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_arith_pkg.sv
// Shared IEEE-754 arithmetic definitions: flag indices, format presets,
// operand classes and small helpers used by the floating-point units.
package fp_arith_pkg;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Right-aligned in 64 bits; callers truncate to their format width.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/multiplier_nbit.sv
// Unsigned WIDTH x WIDTH combinational multiplier.
// IMPL_TYPE 0 infers the operator; any other value builds shift-and-add.
module multiplier_nbit #(
  parameter int WIDTH     = 24,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  if (IMPL_TYPE == 0) begin : g_op
    assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end else begin : g_sa
    always_comb begin
      p = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (b[i]) p = p + ({{WIDTH{1'b0}}, a} << i);
      end
    end
  end

endmodule

// File: rtl/fp_multiplier_pipe.sv
// Three-stage IEEE-754 multiplier: classify/exponent, significand
// product, then normalise/round-to-nearest-even/pack into the output.
module fp_multiplier_pipe
  import fp_arith_pkg::*;
#(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int TAG_W     = 4,
  parameter int IMPL_TYPE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [3:0]               out_flags,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] BIAS = EW'(fp_bias(EXP_W));
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

  function automatic fp_class_t classify(
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] f
  );
    if (e == '0)                     return CLS_ZERO;
    else if (e != {EXP_W{1'b1}})     return CLS_NORMAL;
    else if (f == '0)                return CLS_INF;
    else if (f[MAN_W-1])             return CLS_QNAN;
    else                             return CLS_SNAN;
  endfunction

  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // S1 combinational: unpack and special-value resolution
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_t        ca, cb;
  logic             sign, a_nan, b_nan;
  logic             sp;
  logic [W-1:0]     sp_res;
  logic [3:0]       sp_flags;
  logic signed [EW-1:0] exp_sum;

  assign ea = in_a[MAN_W +: EXP_W];
  assign eb = in_b[MAN_W +: EXP_W];
  assign fa = in_a[MAN_W-1:0];
  assign fb = in_b[MAN_W-1:0];
  assign ca = classify(ea, fa);
  assign cb = classify(eb, fb);
  assign sign  = in_a[W-1] ^ in_b[W-1];
  assign a_nan = (ca == CLS_QNAN) | (ca == CLS_SNAN);
  assign b_nan = (cb == CLS_QNAN) | (cb == CLS_SNAN);
  assign exp_sum = EW'(ea) + EW'(eb) - BIAS;

  always_comb begin
    sp       = 1'b1;
    sp_res   = '0;
    sp_flags = '0;
    if (a_nan | b_nan |
        (ca == CLS_INF & cb == CLS_ZERO) |
        (cb == CLS_INF & ca == CLS_ZERO)) begin
      sp_res = QNAN;
      sp_flags[FLAG_INVALID] = (a_nan | b_nan) ?
        ((ca == CLS_SNAN) | (cb == CLS_SNAN)) : 1'b1;
    end else if (ca == CLS_INF | cb == CLS_INF) begin
      sp_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == CLS_ZERO | cb == CLS_ZERO) begin
      sp_res = {sign, {(W-1){1'b0}}};
    end else begin
      sp = 1'b0;
    end
  end

  logic                 s1_valid, s1_sign, s1_sp;
  logic [TAG_W-1:0]     s1_tag;
  logic [SW-1:0]        s1_sig_a, s1_sig_b;
  logic signed [EW-1:0] s1_exp;
  logic [W-1:0]         s1_sp_res;
  logic [3:0]           s1_sp_flags;

  logic                 s2_valid, s2_sign, s2_sp;
  logic [TAG_W-1:0]     s2_tag;
  logic [PW-1:0]        s2_prod;
  logic signed [EW-1:0] s2_exp;
  logic [W-1:0]         s2_sp_res;
  logic [3:0]           s2_sp_flags;

  logic [PW-1:0] prod;

  multiplier_nbit #(
    .WIDTH     (SW),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_mul (
    .a (s1_sig_a),
    .b (s1_sig_b),
    .p (prod)
  );

  // S3 combinational: normalise (leading one dropped), round, pack
  logic [PW-2:0]        norm;
  logic [MAN_W-1:0]     mant, mant_r;
  logic                 guard, rnd, sticky, round_up, inexact;
  logic [MAN_W:0]       mant_sum;
  logic signed [EW-1:0] exp_n, exp_f;
  logic [W-1:0]         rnd_res;
  logic [3:0]           rnd_flags;

  assign norm = s2_prod[PW-1] ? s2_prod[PW-2:0]
                              : {s2_prod[PW-3:0], 1'b0};
  assign mant     = norm[PW-2 -: MAN_W];
  assign guard    = norm[MAN_W];
  assign rnd      = norm[MAN_W-1];
  assign sticky   = |norm[MAN_W-2:0];
  assign round_up = guard & (rnd | sticky | mant[0]);
  assign inexact  = guard | rnd | sticky;
  assign mant_sum = {1'b0, mant} + (MAN_W+1)'(round_up);
  assign mant_r   = mant_sum[MAN_W-1:0];
  assign exp_n    = s2_exp + EW'(s2_prod[PW-1]);
  assign exp_f    = exp_n + EW'(mant_sum[MAN_W]);

  always_comb begin
    rnd_res   = {s2_sign, exp_f[EXP_W-1:0], mant_r};
    rnd_flags = '0;
    rnd_flags[FLAG_INEXACT] = inexact;
    if (exp_f >= EXP_MAX) begin
      rnd_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags[FLAG_OVERFLOW] = 1'b1;
      rnd_flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_f[EW-1] | (exp_f == '0)) begin
      rnd_res = {s2_sign, {(W-1){1'b0}}};
      rnd_flags[FLAG_UNDERFLOW] = 1'b1;
      rnd_flags[FLAG_INEXACT]   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_sp       <= 1'b0;
      s1_tag      <= '0;
      s1_sig_a    <= '0;
      s1_sig_b    <= '0;
      s1_exp      <= '0;
      s1_sp_res   <= '0;
      s1_sp_flags <= '0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_sp       <= 1'b0;
      s2_tag      <= '0;
      s2_prod     <= '0;
      s2_exp      <= '0;
      s2_sp_res   <= '0;
      s2_sp_flags <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_flags   <= '0;
      out_tag     <= '0;
    end else if (advance) begin
      s1_valid    <= in_valid;
      s1_sign     <= sign;
      s1_sp       <= sp;
      s1_tag      <= in_tag;
      s1_sig_a    <= {1'b1, fa};
      s1_sig_b    <= {1'b1, fb};
      s1_exp      <= exp_sum;
      s1_sp_res   <= sp_res;
      s1_sp_flags <= sp_flags;
      s2_valid    <= s1_valid;
      s2_sign     <= s1_sign;
      s2_sp       <= s1_sp;
      s2_tag      <= s1_tag;
      s2_prod     <= prod;
      s2_exp      <= s1_exp;
      s2_sp_res   <= s1_sp_res;
      s2_sp_flags <= s1_sp_flags;
      out_valid   <= s2_valid;
      out_tag     <= s2_tag;
      out_result  <= s2_sp ? s2_sp_res : rnd_res;
      out_flags   <= s2_sp ? s2_sp_flags : rnd_flags;
    end
  end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed bench for fp_multiplier_pipe: fp32 arithmetic and specials,
// bf16/fp16 instances, backpressure ordering and mid-stream reset.
module tb_fp_multiplier_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0]  in_tag, out_tag, out_flags;

  logic        bf_valid, bf_in_ready, bf_out_valid;
  logic [15:0] bf_a, bf_b, bf_result;
  logic [3:0]  bf_flags, bf_tag;

  logic        hf_valid, hf_in_ready, hf_out_valid;
  logic [15:0] hf_a, hf_b, hf_result;
  logic [3:0]  hf_flags, hf_tag;

  logic        sink_ready;

  fp_multiplier_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag)
  );

  fp_multiplier_pipe #(.EXP_W(8), .MAN_W(7)) u_bf16 (
    .clk(clk), .rst(rst),
    .in_valid(bf_valid), .in_ready(bf_in_ready),
    .in_a(bf_a), .in_b(bf_b), .in_tag(4'h3),
    .out_valid(bf_out_valid), .out_ready(sink_ready),
    .out_result(bf_result), .out_flags(bf_flags), .out_tag(bf_tag)
  );

  fp_multiplier_pipe #(.EXP_W(5), .MAN_W(10)) u_fp16 (
    .clk(clk), .rst(rst),
    .in_valid(hf_valid), .in_ready(hf_in_ready),
    .in_a(hf_a), .in_b(hf_b), .in_tag(4'h6),
    .out_valid(hf_out_valid), .out_ready(sink_ready),
    .out_result(hf_result), .out_flags(hf_flags), .out_tag(hf_tag)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a pair for one cycle; result must show 3 edges later.
  task automatic run_one(input string name, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] er, input logic [3:0] ef);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    tick();
    in_valid = 1'b0;
    tick();
    check({name, "/early"}, out_valid, 0);
    tick();
    check({name, "/valid"}, out_valid, 1);
    check({name, "/res"}, out_result, er);
    check({name, "/flags"}, out_flags, ef);
    check({name, "/tag"}, out_tag, tag);
  endtask

  logic [31:0] bp_a [6];
  logic [31:0] bp_r [6];
  int          sent, rcv;
  logic        stalled, saw_block, fire_in, fire_out;
  logic [31:0] hold_res;
  logic [3:0]  hold_tag, hold_flags;

  initial begin
    bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000,
             32'h40800000, 32'h40A00000, 32'h40C00000};
    bp_r = '{32'h40000000, 32'h40800000, 32'h40C00000,
             32'h41000000, 32'h41200000, 32'h41400000};
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1; sink_ready = 1'b1;
    bf_valid = 1'b0; bf_a = '0; bf_b = '0;
    hf_valid = 1'b0; hf_a = '0; hf_b = '0;
    #12;
    check("reset/valid", out_valid, 0);
    check("reset/res", out_result, 0);
    check("reset/flags", out_flags, 0);
    check("reset/tag", out_tag, 0);
    rst = 1'b0;
    tick();
    check("reset/in_ready", in_ready, 1);

    run_one("mul1p5x2", 32'h3FC00000, 32'h40000000, 4'h5, 32'h40400000, 4'h0);
    run_one("tie_even", 32'h3F800001, 32'h3FC00000, 4'h1, 32'h3FC00002, 4'h1);
    run_one("sticky", 32'h3F800001, 32'h3F800001, 4'h2, 32'h3F800002, 4'h1);
    run_one("rnd_carry", 32'h3FFFFFFF, 32'h3F800001, 4'h3, 32'h40000000, 4'h1);
    run_one("neg", 32'hC0000000, 32'h40400000, 4'h4, 32'hC0C00000, 4'h0);
    run_one("inf_x0", 32'h7F800000, 32'h00000000, 4'h6, 32'h7FC00000, 4'h8);
    run_one("ninf_x2", 32'hFF800000, 32'h40000000, 4'h7, 32'hFF800000, 4'h0);
    run_one("qnan", 32'h7FC00001, 32'h3F800000, 4'h8, 32'h7FC00000, 4'h0);
    run_one("snan", 32'h7F800001, 32'h3F800000, 4'h9, 32'h7FC00000, 4'h8);
    run_one("ovf", 32'h7F000000, 32'h40000000, 4'hA, 32'h7F800000, 4'h5);
    run_one("unf", 32'h00800000, 32'h3F000000, 4'hB, 32'h00000000, 4'h3);
    run_one("daz", 32'h00000001, 32'h3F800000, 4'hC, 32'h00000000, 4'h0);
    run_one("negzero", 32'h80000000, 32'h3F800000, 4'hD, 32'h80000000, 4'h0);

    bf_valid = 1'b1; bf_a = 16'h3FC0; bf_b = 16'h4000;
    hf_valid = 1'b1; hf_a = 16'h3E00; hf_b = 16'h4000;
    tick();
    bf_valid = 1'b0; hf_valid = 1'b0;
    tick();
    tick();
    check("bf16/valid", bf_out_valid, 1);
    check("bf16/res", bf_result, 16'h4040);
    check("bf16/flags", bf_flags, 0);
    check("fp16/valid", hf_out_valid, 1);
    check("fp16/res", hf_result, 16'h4200);
    check("fp16/flags", hf_flags, 0);

    // drain, then six pairs against a stalled consumer
    tick();
    out_ready = 1'b0;
    sent = 0; rcv = 0;
    stalled = 1'b0; saw_block = 1'b0;
    for (int cyc = 0; cyc < 100 && rcv < 6; cyc++) begin
      if (stalled) begin
        check("bp/hold_valid", out_valid, 1);
        check("bp/hold_res", out_result, hold_res);
        check("bp/hold_tag", out_tag, hold_tag);
        check("bp/hold_flags", out_flags, hold_flags);
      end
      out_ready = (cyc < 5) ? 1'b0 : ($urandom_range(0, 2) != 0);
      in_valid = (sent < 6);
      if (sent < 6) begin
        in_a = bp_a[sent];
        in_b = 32'h40000000;
        in_tag = sent[3:0];
      end
      #1;
      if (cyc == 4) begin
        check("bp/in_ready_low", in_ready, 0);
        check("bp/accepted", sent, 3);
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      stalled  = out_valid & !out_ready;
      hold_res = out_result;
      hold_tag = out_tag;
      hold_flags = out_flags;
      if (fire_out) begin
        check("bp/res", out_result, (rcv < 6) ? bp_r[rcv] : 32'h0);
        check("bp/tag", out_tag, 64'(rcv));
        rcv++;
      end
      tick();
      if (fire_in) sent++;
    end
    in_valid = 1'b0;
    check("bp/all_in", sent, 6);
    check("bp/all_out", rcv, 6);
    check("bp/in_ready_fell", saw_block, 1);

    // reset with three operations in flight
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_a = 32'h3FC00000;
      in_b = 32'h40000000;
      in_tag = 4'(k + 1);
      tick();
    end
    in_valid = 1'b0;
    check("rst/pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst/valid", out_valid, 0);
    check("rst/res", out_result, 0);
    check("rst/flags", out_flags, 0);
    check("rst/tag", out_tag, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst/in_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      check("rst/no_ghost", out_valid, 0);
      tick();
    end
    run_one("rst/new", 32'h40400000, 32'h40400000, 4'hE, 32'h41100000, 4'h0);
    tick();
    check("rst/no_dup", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
